// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a decoupling fetch queue toward ID.
// Issues one icache request at a time and buffers {pc, instr} entries so
// fetch keeps running while ID stalls; a MEM redirect flushes the queue.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect_valid/_pc       taken branch/jump target from MEM
//   imem_read/_address       icache request, held until imem_resp
//   imem_resp/_rdata         one-cycle response strobe and instruction
//   id_valid/_pc/_instr      queue head presented to ID (zero when empty)
//   id_ready                 ID accepts the head this cycle
//   fq_count                 occupied queue entries
module if_fetch_queue #(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          imem_read,
    output logic [31:0]                   imem_address,
    input  logic                          imem_resp,
    input  logic [31:0]                   imem_rdata,
    output logic                          id_valid,
    output logic [31:0]                   id_pc,
    output logic [31:0]                   id_instr,
    input  logic                          id_ready,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] lvl;
    logic          push, pop, flush;

    logic [31:0] mem_pc    [FQ_DEPTH];
    logic [31:0] mem_instr [FQ_DEPTH];

    assign imem_read    = (state_q != IDLE);
    assign imem_address = req_addr_q;
    assign id_valid     = (count_q != '0);
    assign id_pc        = id_valid ? mem_pc[head_q] : '0;
    assign id_instr     = id_valid ? mem_instr[head_q] : '0;
    assign fq_count     = count_q;

    assign pop = id_valid & id_ready;
    // Occupancy after a push in this cycle, accounting for a concurrent pop.
    assign lvl = pop ? count_q : count_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end else if (count_q < FULL) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    // A same-cycle response is dropped and the target
                    // issued at once; otherwise wait out the in-flight one
                    // with the address held stable.
                    if (imem_resp) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = KILL;
                    end
                end else if (imem_resp) begin
                    push       = 1'b1;
                    fetch_pc_d = req_addr_q + 32'd4;
                    if (lvl < FULL) begin
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    req_addr_d = redirect_valid ? redirect_pc : fetch_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + PW'(1);
            if (push) tail_d = tail_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_pc[tail_q]    <= req_addr_q;
            mem_instr[tail_q] <= imem_rdata;
        end
    end

endmodule
